// File: rtl/aes128_pipeline_top.sv
// aes128_pipeline_top
//   Fully unrolled AES-128 encryption core (encrypt only), five register
//   stages with two rounds per stage. The round key travels down the pipe
//   next to its block, so every block may use its own key. A block sampled
//   at rising edge k appears on cryptokey right after rising edge k+4.
//
// Ports
//   clk        in   1    rising-edge clock
//   reset      in   1    asynchronous, active-low; clears every stage register
//   data_in    in   128  plaintext, bits 127:120 = state byte 0
//   key        in   128  cipher key, same byte order
//   cryptokey  out  128  ciphertext, driven straight from the stage-5 register

`timescale 1ns/1ps

module aes128_pipeline_top (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic [127:0] cryptokey
);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int round);
    case (round)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Byte index is 4*column + row; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0  = rk[127:96];
    w1  = rk[95:64];
    w2  = rk[63:32];
    w3  = rk[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s));
    if (!last) t = mix_columns(t);
    return t ^ rk;
  endfunction

  logic [127:0] st_q [5];
  logic [127:0] rk_q [5];
  logic [127:0] st_d [5];
  logic [127:0] rk_d [5];

  // Stage g performs rounds 2g+1 and 2g+2; the final round skips MixColumns.
  for (genvar g = 0; g < 5; g++) begin : g_stage
    logic [127:0] st_in, rk_in, rk_a, st_a;
    if (g == 0) begin : g_first
      assign st_in = data_in ^ key;
      assign rk_in = key;
    end else begin : g_next
      assign st_in = st_q[g-1];
      assign rk_in = rk_q[g-1];
    end
    assign rk_a    = key_expand(rk_in, rcon(2*g+1));
    assign st_a    = aes_round(st_in, rk_a, 1'b0);
    assign rk_d[g] = key_expand(rk_a, rcon(2*g+2));
    assign st_d[g] = aes_round(st_a, rk_d[g], (g == 4));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        st_q[i] <= '0;
        rk_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        st_q[i] <= st_d[i];
        rk_q[i] <= rk_d[i];
      end
    end
  end

  assign cryptokey = st_q[4];

endmodule

// File: tb/tb_aes128_pipeline_top.sv
`timescale 1ns/1ps

module tb_aes128_pipeline_top;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] data_in;
  logic [127:0] key;
  logic [127:0] cryptokey;

  int checks   = 0;
  int failures = 0;

  // Vector table: 0 = all-zero, 1 = FIPS-197 C.1 (A), 2 = second vector (B).
  logic [127:0] pt [3];
  logic [127:0] ky [3];
  logic [127:0] ct [3];

  // Expected-output delay line: an output is checkable once five
  // consecutive edges with reset high have been modelled.
  logic [127:0] exp_pipe [5];
  logic [4:0]   vld;

  always #5 clk = ~clk;

  aes128_pipeline_top dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .key       (key),
    .cryptokey (cryptokey)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    vld = '0;
    for (int i = 0; i < 5; i++) exp_pipe[i] = '0;
  endtask

  task automatic tick(input int v, input string tag);
    @(negedge clk);
    data_in = pt[v];
    key     = ky[v];
    @(posedge clk);
    if (reset) begin
      for (int i = 4; i > 0; i--) exp_pipe[i] = exp_pipe[i-1];
      exp_pipe[0] = ct[v];
      vld = {vld[3:0], 1'b1};
    end
    #1;
    if (!reset)       check_val({tag, "_in_reset"}, cryptokey, 128'h0);
    else if (vld[4])  check_val(tag, cryptokey, exp_pipe[4]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pt[0] = 128'h0;
    ky[0] = 128'h0;
    ct[0] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    pt[1] = 128'h00112233445566778899aabbccddeeff;
    ky[1] = 128'h000102030405060708090a0b0c0d0e0f;
    ct[1] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pt[2] = 128'h0123456789abcdeffedcba9876543210;
    ky[2] = 128'h0f1571c947d9e8590cb7add6af7f6798;
    ct[2] = 128'hff0b844a0853bf7c6934ab4364148fb9;

    reset   = 1'b0;
    data_in = '0;
    key     = '0;
    model_clear();

    // Reset held with random inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      data_in = {$urandom, $urandom, $urandom, $urandom};
      key     = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      check_val("reset_hold", cryptokey, 128'h0);
    end

    @(negedge clk);
    reset = 1'b1;

    // Zero vector fill, then a lone A: the cycle before A arrives must
    // still show the zero-vector ciphertext.
    for (int i = 0; i < 5; i++) tick(0, "zero_vec");
    tick(1, "fips_c1");
    for (int i = 0; i < 5; i++) tick(0, "after_c1");

    // Back-to-back A,A,B,A,B with per-block keys.
    tick(1, "stream_a0");
    tick(1, "stream_a1");
    tick(2, "stream_b2");
    tick(1, "stream_a3");
    tick(2, "stream_b4");
    for (int i = 0; i < 4; i++) tick(0, "stream_drain");

    // Asynchronous reset between edges while valid data is on the output.
    tick(2, "pre_rst");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_val("async_rst", cryptokey, 128'h0);
    model_clear();
    tick(1, "rst_hold");
    tick(2, "rst_hold");

    @(negedge clk);
    reset = 1'b1;
    tick(2, "restream_b");
    for (int i = 0; i < 5; i++) tick(0, "restream_tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
